// File: rtl/oclib_pipeline_rv.sv
// Length-stage ready/valid register pipeline built from 2-entry skid slices, with flush and occupancy.
// Latency: a word accepted at edge N is on outData with outValid=1 after edge N+Length-1; Length=0 is a wire.
// Backpressure: every stage ready is registered; inReady drops only when stage 0 holds two words or reset is high.
module oclib_pipeline_rv #(
    parameter int Width     = 1,
    parameter int Length    = 1,
    parameter bit DontTouch = 1'b0,
    parameter int OccWidth  = (Length == 0) ? 1 : $clog2(2 * Length + 1)
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                flush,
    input  logic [Width-1:0]    inData,
    input  logic                inValid,
    output logic                inReady,
    output logic [Width-1:0]    outData,
    output logic                outValid,
    input  logic                outReady,
    output logic [OccWidth-1:0] occupancy
);

    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_ONE   = 2'd1;
    localparam logic [1:0] ST_TWO   = 2'd2;

    if (Length == 0) begin : g_wire
        logic unused_ctl;

        assign outData   = inData;
        assign outValid  = inValid;
        assign inReady   = outReady;
        assign occupancy = '0;
        assign unused_ctl = ^{clock, reset, flush};
    end else begin : g_pipe
        // Index k is the boundary feeding stage k; index Length is the downstream port.
        logic [Length:0]   pipe_vld;
        logic [Length:0]   pipe_rdy;
        logic [Width-1:0]  pipe_dat [Length+1];
        logic              acc_fire;
        logic              dlv_fire;
        logic [OccWidth-1:0] occ_q;

        assign pipe_vld[0]      = inValid;
        assign pipe_dat[0]      = inData;
        assign pipe_rdy[Length] = outReady;

        assign inReady   = pipe_rdy[0] & ~reset;
        assign outValid  = pipe_vld[Length];
        assign outData   = pipe_dat[Length];

        for (genvar k = 0; k < Length; k++) begin : g_stage
            logic [1:0]       state_cur;
            logic [1:0]       state_nxt;
            logic [Width-1:0] main_cur;
            logic [Width-1:0] main_nxt;
            logic [Width-1:0] skid_cur;
            logic [Width-1:0] skid_nxt;
            logic             in_fire;
            logic             out_fire;

            assign in_fire        = pipe_vld[k] & pipe_rdy[k];
            assign out_fire       = pipe_vld[k+1] & pipe_rdy[k+1];
            assign pipe_rdy[k]    = (state_cur != ST_TWO);
            assign pipe_vld[k+1]  = (state_cur != ST_EMPTY);
            assign pipe_dat[k+1]  = main_cur;

            always_comb begin
                state_nxt = state_cur;
                main_nxt  = main_cur;
                skid_nxt  = skid_cur;
                case (state_cur)
                    ST_EMPTY: begin
                        if (in_fire) begin
                            state_nxt = ST_ONE;
                            main_nxt  = pipe_dat[k];
                        end
                    end
                    ST_ONE: begin
                        if (in_fire && !out_fire) begin
                            state_nxt = ST_TWO;
                            skid_nxt  = pipe_dat[k];
                        end else if (in_fire && out_fire) begin
                            main_nxt  = pipe_dat[k];
                        end else if (out_fire) begin
                            state_nxt = ST_EMPTY;
                        end
                    end
                    ST_TWO: begin
                        if (out_fire) begin
                            state_nxt = ST_ONE;
                            main_nxt  = skid_cur;
                        end
                    end
                    default: state_nxt = ST_EMPTY;
                endcase
                if (flush) begin
                    state_nxt = ST_EMPTY;
                end
            end

            if (DontTouch) begin : g_keep
                (* dont_touch = "true" *) logic [1:0]       state_q;
                (* dont_touch = "true" *) logic [Width-1:0] main_q;
                (* dont_touch = "true" *) logic [Width-1:0] skid_q;

                always_ff @(posedge clock) begin
                    if (reset) begin
                        state_q <= ST_EMPTY;
                    end else begin
                        state_q <= state_nxt;
                    end
                    main_q <= main_nxt;
                    skid_q <= skid_nxt;
                end

                assign state_cur = state_q;
                assign main_cur  = main_q;
                assign skid_cur  = skid_q;
            end else begin : g_plain
                logic [1:0]       state_q;
                logic [Width-1:0] main_q;
                logic [Width-1:0] skid_q;

                always_ff @(posedge clock) begin
                    if (reset) begin
                        state_q <= ST_EMPTY;
                    end else begin
                        state_q <= state_nxt;
                    end
                    main_q <= main_nxt;
                    skid_q <= skid_nxt;
                end

                assign state_cur = state_q;
                assign main_cur  = main_q;
                assign skid_cur  = skid_q;
            end
        end

        // Tracking edge transfers keeps the count equal to the per-stage sum without an adder tree.
        assign acc_fire = pipe_vld[0] & pipe_rdy[0];
        assign dlv_fire = pipe_vld[Length] & pipe_rdy[Length];

        always_ff @(posedge clock) begin
            if (reset || flush) begin
                occ_q <= '0;
            end else begin
                occ_q <= occ_q + OccWidth'(acc_fire) - OccWidth'(dlv_fire);
            end
        end

        assign occupancy = occ_q;
    end

endmodule

// File: tb/tb_oclib_pipeline_rv.sv
// Bench for oclib_pipeline_rv: reset, latency/throughput, fill, random stall, flush/reset, passthrough.
module tb_oclib_pipeline_rv;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;

    logic rst   = 1'b1;
    logic a_rst = 1'b1;
    logic d_rst = 1'b1;

    // a: Length=3, Width=8
    logic       a_flush = 1'b0, a_in_vld = 1'b0, a_out_rdy = 1'b0;
    logic       a_in_rdy, a_out_vld;
    logic [7:0] a_in_dat = '0, a_out_dat;
    logic [2:0] a_occ;
    // b: Length=2, Width=8
    logic       b_flush = 1'b0, b_in_vld = 1'b0, b_out_rdy = 1'b0;
    logic       b_in_rdy, b_out_vld;
    logic [7:0] b_in_dat = '0, b_out_dat;
    logic [2:0] b_occ;
    // c: Length=4, Width=16
    logic        c_flush = 1'b0, c_in_vld = 1'b0, c_out_rdy = 1'b0;
    logic        c_in_rdy, c_out_vld;
    logic [15:0] c_in_dat = '0, c_out_dat;
    logic [3:0]  c_occ;
    // d: Length=0, Width=8
    logic       d_flush = 1'b0, d_in_vld = 1'b0, d_out_rdy = 1'b0;
    logic       d_in_rdy, d_out_vld;
    logic [7:0] d_in_dat = '0, d_out_dat;
    logic [0:0] d_occ;

    oclib_pipeline_rv #(.Width(8), .Length(3)) u_a (
        .clock(clock), .reset(a_rst), .flush(a_flush),
        .inData(a_in_dat), .inValid(a_in_vld), .inReady(a_in_rdy),
        .outData(a_out_dat), .outValid(a_out_vld), .outReady(a_out_rdy),
        .occupancy(a_occ));

    oclib_pipeline_rv #(.Width(8), .Length(2), .DontTouch(1'b1)) u_b (
        .clock(clock), .reset(rst), .flush(b_flush),
        .inData(b_in_dat), .inValid(b_in_vld), .inReady(b_in_rdy),
        .outData(b_out_dat), .outValid(b_out_vld), .outReady(b_out_rdy),
        .occupancy(b_occ));

    oclib_pipeline_rv #(.Width(16), .Length(4)) u_c (
        .clock(clock), .reset(rst), .flush(c_flush),
        .inData(c_in_dat), .inValid(c_in_vld), .inReady(c_in_rdy),
        .outData(c_out_dat), .outValid(c_out_vld), .outReady(c_out_rdy),
        .occupancy(c_occ));

    oclib_pipeline_rv #(.Width(8), .Length(0)) u_d (
        .clock(clock), .reset(d_rst), .flush(d_flush),
        .inData(d_in_dat), .inValid(d_in_vld), .inReady(d_in_rdy),
        .outData(d_out_dat), .outValid(d_out_vld), .outReady(d_out_rdy),
        .occupancy(d_occ));

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            n_checks++;
            if (a_in_rdy !== 1'b0) begin n_fail++; $display("FAIL reset_in_rdy: got %b expected 0", a_in_rdy); end
            n_checks++;
            if (a_out_vld !== 1'b0) begin n_fail++; $display("FAIL reset_out_vld: got %b expected 0", a_out_vld); end
            n_checks++;
            if (a_occ !== 3'd0) begin n_fail++; $display("FAIL reset_occ: got %0d expected 0", a_occ); end
        end
        a_rst = 1'b0;
        rst   = 1'b0;
        d_rst = 1'b0;
        #1;
        n_checks++;
        if (a_in_rdy !== 1'b1) begin n_fail++; $display("FAIL release_in_rdy: got %b expected 1", a_in_rdy); end
        n_checks++;
        if (a_out_vld !== 1'b0) begin n_fail++; $display("FAIL release_out_vld: got %b expected 0", a_out_vld); end
        n_checks++;
        if (a_occ !== 3'd0) begin n_fail++; $display("FAIL release_occ: got %0d expected 0", a_occ); end
        n_checks++;
        if (b_in_rdy !== 1'b1) begin n_fail++; $display("FAIL release_b_in_rdy: got %b expected 1", b_in_rdy); end
    endtask

    task automatic test_latency();
        logic [7:0] q[$];
        logic [7:0] exp_dat;
        int sent = 0, got = 0, cyc = 0, first_in = -1, first_out = -1, bubbles = 0;
        a_out_rdy = 1'b1;
        while (got < 32 && cyc < 200) begin
            @(negedge clock);
            if (a_out_vld) begin
                if (first_out < 0) first_out = cyc;
            end else if (first_out >= 0) begin
                bubbles++;
            end
            if (sent < 32) begin
                a_in_vld = 1'b1;
                a_in_dat = 8'(sent + 1);
                if (first_in < 0) first_in = cyc;
            end else begin
                a_in_vld = 1'b0;
            end
            if (a_out_vld && a_out_rdy) begin
                exp_dat = (q.size() > 0) ? q.pop_front() : 8'hxx;
                n_checks++;
                if (a_out_dat !== exp_dat) begin n_fail++; $display("FAIL latency_data: got %h expected %h", a_out_dat, exp_dat); end
                got++;
            end
            if (a_in_vld && a_in_rdy) begin
                q.push_back(a_in_dat);
                sent++;
            end
            cyc++;
        end
        a_in_vld = 1'b0;
        n_checks++;
        if (got !== 32) begin n_fail++; $display("FAIL latency_count: got %0d words expected 32", got); end
        n_checks++;
        if (first_out - first_in !== 3) begin n_fail++; $display("FAIL latency_first: got %0d cycles expected 3", first_out - first_in); end
        n_checks++;
        if (bubbles !== 0) begin n_fail++; $display("FAIL latency_bubbles: got %0d expected 0", bubbles); end
    endtask

    task automatic test_backpressure();
        logic [7:0] q[$];
        logic [7:0] exp_dat;
        int sent = 0, got = 0, first_dlv = -1, rdy_back = -1;
        b_out_rdy = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clock);
            b_in_vld = 1'b1;
            b_in_dat = 8'(sent);
            if (b_in_rdy) begin
                q.push_back(b_in_dat);
                sent++;
            end
        end
        @(negedge clock);
        b_in_vld = 1'b0;
        n_checks++;
        if (sent !== 4) begin n_fail++; $display("FAIL fill_accepted: got %0d expected 4", sent); end
        n_checks++;
        if (b_in_rdy !== 1'b0) begin n_fail++; $display("FAIL fill_in_rdy: got %b expected 0", b_in_rdy); end
        n_checks++;
        if (b_occ !== 3'd4) begin n_fail++; $display("FAIL fill_occ: got %0d expected 4", b_occ); end
        for (int cyc = 0; cyc < 20 && got < 4; cyc++) begin
            if (cyc > 0) @(negedge clock);
            b_out_rdy = 1'b1;
            if (first_dlv >= 0 && rdy_back < 0 && b_in_rdy) rdy_back = cyc;
            if (b_out_vld) begin
                exp_dat = (q.size() > 0) ? q.pop_front() : 8'hxx;
                n_checks++;
                if (b_out_dat !== exp_dat) begin n_fail++; $display("FAIL drain_data: got %h expected %h", b_out_dat, exp_dat); end
                if (first_dlv < 0) first_dlv = cyc;
                got++;
            end
        end
        @(negedge clock);
        n_checks++;
        if (got !== 4) begin n_fail++; $display("FAIL drain_count: got %0d expected 4", got); end
        n_checks++;
        if (rdy_back < 0 || rdy_back - first_dlv < 1 || rdy_back - first_dlv > 2) begin
            n_fail++; $display("FAIL drain_in_rdy_return: got offset %0d expected 1..2", rdy_back - first_dlv);
        end
        n_checks++;
        if (b_occ !== 3'd0 || b_out_vld !== 1'b0) begin n_fail++; $display("FAIL drain_empty: got occ %0d vld %b expected 0 0", b_occ, b_out_vld); end
        b_out_rdy = 1'b0;
    endtask

    task automatic test_random();
        localparam int N = 10000;
        logic [15:0] q[$];
        logic [15:0] exp_dat;
        int sent = 0, got = 0, cyc = 0, errs = 0;
        while (got < N && cyc < 60000 && errs < 20) begin
            @(negedge clock);
            n_checks++;
            if (c_occ !== 4'(sent - got)) begin
                n_fail++; errs++;
                $display("FAIL random_occ: got %0d expected %0d", c_occ, sent - got);
            end
            c_out_rdy = ($urandom_range(1, 0) == 1);
            c_in_vld  = (sent < N) && ($urandom_range(1, 0) == 1);
            c_in_dat  = 16'($urandom);
            if (c_out_vld && c_out_rdy) begin
                exp_dat = (q.size() > 0) ? q.pop_front() : 16'hxxxx;
                n_checks++;
                if (c_out_dat !== exp_dat) begin
                    n_fail++; errs++;
                    $display("FAIL random_data: got %h expected %h", c_out_dat, exp_dat);
                end
                got++;
            end
            if (c_in_vld && c_in_rdy) begin
                q.push_back(c_in_dat);
                sent++;
            end
            cyc++;
        end
        c_in_vld  = 1'b0;
        c_out_rdy = 1'b0;
        n_checks++;
        if (got !== N) begin n_fail++; $display("FAIL random_count: got %0d expected %0d", got, N); end
    endtask

    task automatic test_flush_reset();
        for (int mode = 0; mode < 2; mode++) begin
            logic [7:0] q[$];
            logic [7:0] exp_dat;
            int sent = 0, got = 0;
            a_out_rdy = 1'b0;
            for (int i = 0; i < 20 && sent < 5; i++) begin
                @(negedge clock);
                a_in_vld = 1'b1;
                a_in_dat = 8'h40 + 8'(sent);
                if (a_in_rdy) sent++;
            end
            @(negedge clock);
            n_checks++;
            if (a_occ !== 3'd5) begin n_fail++; $display("FAIL clear_hold_occ mode %0d: got %0d expected 5", mode, a_occ); end
            a_in_vld = 1'b1;
            a_in_dat = 8'hEE;
            if (mode == 0) a_flush = 1'b1;
            else a_rst = 1'b1;
            #1;
            if (mode == 1) begin
                n_checks++;
                if (a_in_rdy !== 1'b0) begin n_fail++; $display("FAIL reset_mid_in_rdy: got %b expected 0", a_in_rdy); end
            end
            @(negedge clock);
            a_flush  = 1'b0;
            a_rst    = 1'b0;
            a_in_vld = 1'b0;
            #1;
            n_checks++;
            if (a_occ !== 3'd0) begin n_fail++; $display("FAIL clear_occ mode %0d: got %0d expected 0", mode, a_occ); end
            n_checks++;
            if (a_out_vld !== 1'b0) begin n_fail++; $display("FAIL clear_out_vld mode %0d: got %b expected 0", mode, a_out_vld); end
            n_checks++;
            if (a_in_rdy !== 1'b1) begin n_fail++; $display("FAIL clear_in_rdy mode %0d: got %b expected 1", mode, a_in_rdy); end
            sent = 0;
            a_out_rdy = 1'b1;
            for (int cyc = 0; cyc < 15; cyc++) begin
                @(negedge clock);
                if (sent < 2) begin
                    a_in_vld = 1'b1;
                    a_in_dat = 8'h51 + 8'(sent);
                end else begin
                    a_in_vld = 1'b0;
                end
                if (a_out_vld && a_out_rdy) begin
                    exp_dat = (q.size() > 0) ? q.pop_front() : 8'hxx;
                    n_checks++;
                    if (a_out_dat !== exp_dat) begin n_fail++; $display("FAIL clear_after_data mode %0d: got %h expected %h", mode, a_out_dat, exp_dat); end
                    got++;
                end
                if (a_in_vld && a_in_rdy) begin
                    q.push_back(a_in_dat);
                    sent++;
                end
            end
            n_checks++;
            if (got !== 2) begin n_fail++; $display("FAIL clear_after_count mode %0d: got %0d expected 2", mode, got); end
        end
        a_out_rdy = 1'b0;
    endtask

    task automatic test_passthrough();
        logic [7:0] exp_dat;
        for (int i = 0; i < 8; i++) begin
            @(negedge clock);
            d_in_dat  = 8'($urandom);
            d_in_vld  = i[0];
            d_out_rdy = i[1];
            d_flush   = i[2];
            d_rst     = i[2] ^ i[0];
            exp_dat   = d_in_dat;
            #1;
            n_checks++;
            if (d_out_dat !== exp_dat) begin n_fail++; $display("FAIL pass_data: got %h expected %h", d_out_dat, exp_dat); end
            n_checks++;
            if (d_out_vld !== i[0]) begin n_fail++; $display("FAIL pass_vld: got %b expected %b", d_out_vld, i[0]); end
            n_checks++;
            if (d_in_rdy !== i[1]) begin n_fail++; $display("FAIL pass_rdy: got %b expected %b", d_in_rdy, i[1]); end
            n_checks++;
            if (d_occ !== 1'b0) begin n_fail++; $display("FAIL pass_occ: got %0d expected 0", d_occ); end
        end
        d_flush = 1'b0;
        d_rst   = 1'b0;
    endtask

    initial begin
        test_reset();
        test_latency();
        test_backpressure();
        test_random();
        test_flush_reset();
        test_passthrough();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
